// File: rtl/barret_1621_rr_sched.sv
// barret_1621_rr_sched: round-robin scheduler sharing one combinational mod-1621 reducer
// Define BARRET_1621_SCHED_PIPE_EN to register the granted operand before the reducer (2-cycle latency)
module barret_1621_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int DW   = 21,
  parameter int RW   = 11,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [DW-1:0]        red_din,
  input  logic [RW-1:0]        red_dout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RW-1:0]        res_data,
  output logic [IDW-1:0]       res_id,
  output logic [CNTW-1:0]      op_count,
  output logic                 busy
);
  localparam int SW = IDW + 1;
  logic [IDW-1:0] ptr, off, g;
  logic [NREQ-1:0] rot;
  logic [SW-1:0] sum;
  logic out_adv, adv, xfer;
  assign out_adv = !res_valid || res_ready;
  // rotate so bit 0 is the requester at ptr, then the lowest set bit is the grant offset
  always_comb begin
    rot = NREQ'({req_valid, req_valid} >> ptr);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) off = rot[i] ? IDW'(i) : off;
    sum = {1'b0, ptr} + {1'b0, off};
    g = (sum >= SW'(NREQ)) ? IDW'(sum - SW'(NREQ)) : sum[IDW-1:0];
  end
  assign xfer = adv && |req_valid && !rst;
  assign req_ready = xfer ? NREQ'(1) << g : '0;
`ifdef BARRET_1621_SCHED_PIPE_EN
  logic s1_valid;
  logic [DW-1:0] s1_data;
  logic [IDW-1:0] s1_id;
  assign adv = !s1_valid || out_adv;
  assign red_din = s1_data;
  assign busy = s1_valid || res_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_id <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_id <= '0;
    end else begin
      if (adv) begin
        s1_valid <= xfer;
        if (xfer) begin
          s1_data <= req_data[g*DW +: DW];
          s1_id <= g;
        end
      end
      if (out_adv) begin
        res_valid <= s1_valid;
        if (s1_valid) begin
          res_data <= red_dout;
          res_id <= s1_id;
        end
      end
    end
  end
`else
  assign adv = out_adv;
  assign red_din = xfer ? req_data[g*DW +: DW] : '0;
  assign busy = res_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data <= '0;
      res_id <= '0;
    end else if (adv) begin
      res_valid <= xfer;
      if (xfer) begin
        res_data <= red_dout;
        res_id <= g;
      end
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      op_count <= '0;
    end else if (xfer) begin
      ptr <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
      op_count <= (&op_count) ? op_count : op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_barret_1621_rr_sched.sv
// tb_barret_1621_rr_sched: directed vector table, full residue sweep and randomized queue-model check
module tb_barret_1621_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DW   = 21;
  localparam int RW   = 11;
  localparam int CNTW = 16;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic [DW-1:0] red_din;
  logic [RW-1:0] red_dout, res_data;
  logic res_valid, res_ready, busy;
  logic [IDW-1:0] res_id;
  logic [CNTW-1:0] op_count;

  barret_1621_rr_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .red_din(red_din), .red_dout(red_dout), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .op_count(op_count), .busy(busy)
  );

  always #5 clk = ~clk;
  assign red_dout = RW'(red_din % DW'(1621));

  typedef struct {
    logic r;
    logic [NREQ-1:0] v;
    logic [NREQ*DW-1:0] d;
    logic rr;
    logic [NREQ-1:0] er;
    logic ev;
    int ed;
    int ei;
    int ec;
  } vec_t;
  typedef struct { int d; int id; } res_t;

  vec_t tbl[15];
  res_t q[$];
  int vecs = 0;
  int errs = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] v, input int d0, input int d1,
                              input int d2, input int d3, input logic rr, input logic [3:0] er,
                              input logic ev, input int ed, input int ei, input int ec);
    vec_t t;
    t.r = r; t.v = v; t.rr = rr; t.er = er; t.ev = ev; t.ed = ed; t.ei = ei; t.ec = ec;
    t.d = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    return t;
  endfunction

  // first requester at or after p (cyclically) with valid set, -1 if none
  function automatic int pick(input int p, input logic [NREQ-1:0] v);
    int r = -1;
    logic [NREQ-1:0] t;
    for (int k = NREQ - 1; k >= 0; k--) begin
      t = v >> ((p + k) % NREQ);
      if (t[0]) r = (p + k) % NREQ;
    end
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic reset2();
    rst = 1'b1;
    req_valid = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int g, m_ptr, m_cnt, exp_din;
    logic [NREQ-1:0] exp_rdy;
    res_t e;
    tbl[0]  = mk(1'b0, 4'b0001, 1621, 0, 0, 0, 1'b1, 4'b0001, 1'b1, 0, 0, 1);
    tbl[1]  = mk(1'b0, 4'b0001, 2097151, 0, 0, 0, 1'b1, 4'b0001, 1'b1, 1198, 0, 2);
    tbl[2]  = mk(1'b0, 4'b0000, 0, 0, 0, 0, 1'b1, 4'b0000, 1'b0, 0, 0, 2);
    tbl[3]  = mk(1'b1, 4'b1111, 1622, 3243, 1620, 5000, 1'b1, 4'b0000, 1'b0, 0, 0, 0);
    tbl[4]  = mk(1'b0, 4'b1111, 1622, 3243, 1620, 5000, 1'b1, 4'b0001, 1'b1, 1, 0, 1);
    tbl[5]  = mk(1'b0, 4'b1111, 1622, 3243, 1620, 5000, 1'b1, 4'b0010, 1'b1, 1, 1, 2);
    tbl[6]  = mk(1'b0, 4'b1111, 1622, 3243, 1620, 5000, 1'b1, 4'b0100, 1'b1, 1620, 2, 3);
    tbl[7]  = mk(1'b0, 4'b1111, 1622, 3243, 1620, 5000, 1'b1, 4'b1000, 1'b1, 137, 3, 4);
    tbl[8]  = mk(1'b0, 4'b1111, 1622, 3243, 1620, 5000, 1'b1, 4'b0001, 1'b1, 1, 0, 5);
    tbl[9]  = mk(1'b0, 4'b1111, 1622, 3243, 1620, 5000, 1'b0, 4'b0000, 1'b1, 1, 0, 5);
    tbl[10] = mk(1'b0, 4'b1111, 1622, 3243, 1620, 5000, 1'b0, 4'b0000, 1'b1, 1, 0, 5);
    tbl[11] = mk(1'b0, 4'b1111, 1622, 3243, 1620, 5000, 1'b0, 4'b0000, 1'b1, 1, 0, 5);
    tbl[12] = mk(1'b0, 4'b1111, 1622, 3243, 1620, 5000, 1'b1, 4'b0010, 1'b1, 1, 1, 6);
    tbl[13] = mk(1'b1, 4'b1111, 1622, 3243, 1620, 5000, 1'b0, 4'b0000, 1'b0, 0, 0, 0);
    tbl[14] = mk(1'b0, 4'b1111, 1622, 3243, 1620, 5000, 1'b1, 4'b0001, 1'b1, 1, 0, 1);

    rst = 1'b1;
    req_valid = '1;
    req_data = '0;
    res_ready = 1'b1;
    #1;
    chk("rst_ready", 32'(req_ready), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_res_data", 32'(res_data), 32'(0));
    chk("rst_res_id", 32'(res_id), 32'(0));
    chk("rst_op_count", 32'(op_count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].r;
      req_valid = tbl[i].v;
      req_data = tbl[i].d;
      res_ready = tbl[i].rr;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].er));
      exp_din = 0;
      for (int k = 0; k < NREQ; k++) if (tbl[i].er[k]) exp_din = int'(tbl[i].d[k*DW +: DW]);
      chk($sformatf("tbl%0d_din", i), 32'(red_din), 32'(exp_din));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(res_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_count", i), 32'(op_count), 32'(tbl[i].ec));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), 32'(res_data), 32'(tbl[i].ed));
        chk($sformatf("tbl%0d_id", i), 32'(res_id), 32'(tbl[i].ei));
      end
    end

    reset2();
    req_valid = 4'b0100;
    req_data = '0;
    res_ready = 1'b1;
    for (int x = 0; x < 1621; x++) begin
      req_data[2*DW +: DW] = DW'(x);
      #1;
      chk("sweep_ready", 32'(req_ready), 32'(4'b0100));
      @(posedge clk);
      #1;
      chk("sweep_valid", 32'(res_valid), 32'(1));
      chk("sweep_data", 32'(res_data), 32'(x));
      chk("sweep_id", 32'(res_id), 32'(2));
    end
    chk("sweep_count", 32'(op_count), 32'(1621));

    reset2();
    m_ptr = 0;
    m_cnt = 0;
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      req_valid = NREQ'($urandom);
      for (int k = 0; k < NREQ; k++) req_data[k*DW +: DW] = DW'($urandom_range(0, 2097151));
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = (rst || !(q.size() == 0 || res_ready)) ? -1 : pick(m_ptr, req_valid);
      exp_rdy = (g < 0) ? '0 : NREQ'(1 << g);
      exp_din = (g < 0) ? 0 : int'(req_data[g*DW +: DW]);
      chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd_din", 32'(red_din), 32'(exp_din));
      @(posedge clk);
      #1;
      if (rst) begin
        q.delete();
        m_ptr = 0;
        m_cnt = 0;
      end else begin
        if (q.size() > 0 && res_ready) void'(q.pop_front());
        if (g >= 0) begin
          e.d = exp_din % 1621;
          e.id = g;
          q.push_back(e);
          m_ptr = (g + 1) % NREQ;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      chk("rnd_valid", 32'(res_valid), 32'(q.size() > 0));
      chk("rnd_busy", 32'(busy), 32'(q.size() > 0));
      chk("rnd_count", 32'(op_count), 32'(m_cnt));
      if (q.size() > 0) begin
        chk("rnd_data", 32'(res_data), 32'(q[0].d));
        chk("rnd_id", 32'(res_id), 32'(q[0].id));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/barret_1621_rr_sched.md
Name: barret_1621_rr_sched

Overview:
- Round-robin scheduler that shares one combinational barret_for_1621 reducer (21-bit in, 11-bit out, mod 1621) between NREQ requesters.
- Accepts one operand per cycle through a valid/ready handshake and drives it into the reducer. Registers the reduced result together with the source ID, then presents it on a single backpressured result port.
- Sits between the polynomial/NTT coefficient producers and the shared reduction unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must equal clog2(NREQ).
- DW, 21, operand width (matches reducer din_a).
- RW, 11, result width (matches reducer dout_r).
- CNTW, 16, width of accepted-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  NREQ*DW  packed operands; requester k uses bits [k*DW +: DW].
- req_ready  out  NREQ  one-hot grant/accept, combinational.
- red_din  out  DW  operand to reducer din_a.
- red_dout  in  RW  reducer dout_r.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  RW  reduced value, operand mod 1621.
- res_id  out  IDW  index of the requester that issued the operand.
- op_count  out  CNTW  accepted-operation counter, saturating.
- busy  out  1  high while any result is held or in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: res_valid=0, res_data=0, res_id=0, op_count=0, busy=0, round-robin pointer ptr=0.
- A reset asserted mid-operation discards any held or in-flight result. No req_ready may be high in the reset cycle.
- Advance condition: adv = !res_valid || res_ready.
- Arbitration when adv=1:
  - Scan from ptr, ptr+1, … modulo NREQ. Grant g is the first index with req_valid[g]=1.
  - Assert req_ready[g]=1; all other req_ready bits are 0.
  - When adv=0, or no req_valid is set, all req_ready bits are 0.
  - A transfer occurs when req_valid[g] && req_ready[g].
- Datapath: red_din equals the granted operand, or 0 when nothing is granted.
- On a transfer, at the next rising edge:
  - res_data<=red_dout, res_id<=g, res_valid<=1.
  - ptr<=(g+1) mod NREQ.
  - op_count increments and saturates at all-ones.
- Latency: 1 cycle from accept to res_valid.
- Throughput: 1 result per cycle while res_ready=1.
- Drain: adv=1 with no transfer and res_ready=1 clears res_valid at the next edge.
- Backpressure: while res_valid && !res_ready, res_data and res_id hold stable, req_ready is all 0, and ptr holds.
- Simultaneous events: a pop (res_ready) and a new accept in the same cycle give back-to-back results with no bubble.
- Fairness: a continuously valid requester is granted within NREQ accepts.
- State machine (implicit in res_valid):
  - EMPTY (res_valid=0): transfer goes to FULL, otherwise stays in EMPTY.
  - FULL (res_valid=1): res_ready with a transfer stays in FULL; res_ready with no transfer goes to EMPTY; !res_ready stays in FULL.
- busy = res_valid.
- Operands follow the reducer's contract (0 ≤ x < 2^21). The scheduler does no range checking.

Optional Feature:
- Macro: BARRET_1621_SCHED_PIPE_EN.
- Defined: a registered stage s1 (operand + ID + valid) is inserted before the reducer.
  - red_din is driven from s1, not from the grant.
  - Latency becomes 2 cycles.
  - s1 advances when !res_valid || res_ready; adv = !s1_valid || that condition.
  - busy = s1_valid || res_valid.
  - Reset clears s1_valid.
  - Ordering and fairness rules are unchanged.
- Undefined: single-stage behaviour exactly as specified above.

Test Plan:
- Single requester: rst for 2 cycles, then requester 0 sends 1621 → req_ready[0]=1 same cycle; next cycle res_valid=1, res_data=0, res_id=0, op_count=1.
- Full sweep: requester 2 sends 0..1620 with res_ready=1 → res_data equals the input each cycle; op_count=1621; no bubbles after the first result.
- Max operand: 2097151 → res_data=1198.
- All four valid continuously, operands 1622, 3243, 1620, 5000 → grant order 0,1,2,3,0…; results 1,1,1620,137 with res_id 0,1,2,3.
- Backpressure: hold res_ready=0 for 3 cycles with a result pending → res_data/res_id stable, req_ready=0, ptr unchanged. Release → next grant is (last g+1).
- Reset mid-stream while res_valid=1 → next cycle res_valid=0, op_count=0, ptr=0, req_ready=0 during reset.
